// File: rtl/register_file_if.sv
// Register file bus: writeback write port, two issue read ports and the
// pending-write scoreboard controls, bundled for connection to the pipeline.
interface register_file_if #(
   parameter int XLEN     = 32,
   parameter int NUM_REGS = 32,
   parameter int ADDR_W   = 5
);
   logic                wr_en;
   logic [ADDR_W-1:0]   wr_addr;
   logic [XLEN-1:0]     wr_data;
   logic [ADDR_W-1:0]   rs1_addr;
   logic [ADDR_W-1:0]   rs2_addr;
   logic                rs1_used;
   logic                rs2_used;
   logic [XLEN-1:0]     rs1_data;
   logic [XLEN-1:0]     rs2_data;
   logic                busy_set_en;
   logic [ADDR_W-1:0]   busy_set_addr;
   logic                rs1_busy;
   logic                rs2_busy;
   logic                stall;
   logic [NUM_REGS-1:0] busy_vec;

   modport slave (
      input  wr_en, wr_addr, wr_data, rs1_addr, rs2_addr, rs1_used, rs2_used,
             busy_set_en, busy_set_addr,
      output rs1_data, rs2_data, rs1_busy, rs2_busy, stall, busy_vec
   );

   modport master (
      output wr_en, wr_addr, wr_data, rs1_addr, rs2_addr, rs1_used, rs2_used,
             busy_set_en, busy_set_addr,
      input  rs1_data, rs2_data, rs1_busy, rs2_busy, stall, busy_vec
   );
endinterface

// File: rtl/register_file.sv
// Architectural integer register file with write bypass on both read ports
// and a one-bit-per-register pending-write scoreboard driving the issue stall.
module register_file #(
   parameter int XLEN     = 32,
   parameter int NUM_REGS = 32,
   parameter int ADDR_W   = 5
) (
   input logic          clk,
   input logic          reset_n,
   register_file_if.slave rf
);

   logic [XLEN-1:0]     regs [NUM_REGS];
   logic [NUM_REGS-1:0] busy_q;
   logic                wr_live;
   logic                hit1;
   logic                hit2;

   // NOTE: the register array is reset explicitly because software relies on
   // every register reading 0 after reset; this keeps it in flops, not a RAM.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      end else if (rf.wr_en && rf.wr_addr != '0) begin
         regs[rf.wr_addr] <= rf.wr_data;
      end
   end

   // Set beats clear: a newly issued producer supersedes the one retiring now.
   // Bit 0 is never assigned outside reset, so x0 can never look busy.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         busy_q <= '0;
      end else begin
         for (int i = 1; i < NUM_REGS; i++) begin
            if (rf.busy_set_en && rf.busy_set_addr == ADDR_W'(i))
               busy_q[i] <= 1'b1;
            else if (rf.wr_en && rf.wr_addr == ADDR_W'(i))
               busy_q[i] <= 1'b0;
         end
      end
   end

   // Bypass is suppressed while in reset so every output reads 0 immediately.
   assign wr_live = reset_n && rf.wr_en;
   assign hit1    = wr_live && rf.wr_addr == rf.rs1_addr;
   assign hit2    = wr_live && rf.wr_addr == rf.rs2_addr;

   assign rf.rs1_data = (rf.rs1_addr == '0) ? '0 :
                        hit1 ? rf.wr_data : regs[rf.rs1_addr];
   assign rf.rs2_data = (rf.rs2_addr == '0) ? '0 :
                        hit2 ? rf.wr_data : regs[rf.rs2_addr];

   // A register written this cycle is not busy: its value is on the bypass.
   assign rf.rs1_busy = (rf.rs1_addr != '0) && busy_q[rf.rs1_addr] && !hit1;
   assign rf.rs2_busy = (rf.rs2_addr != '0) && busy_q[rf.rs2_addr] && !hit2;
   assign rf.stall    = (rf.rs1_used && rf.rs1_busy) || (rf.rs2_used && rf.rs2_busy);
   assign rf.busy_vec = busy_q;

endmodule
